pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the load enables and bubble (flush) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions:
- load-use hazards;
- EX-stage redirects (taken branch or jump);
- instruction-memory stalls, including redirects that arrive while a fetch is outstanding;
- data-memory stalls.

It also keeps saturating performance counters.

---
 rtl/rv32i_types.sv | 5 +
 rtl/pipeline_ctrl_if.sv | 38 +++
 rtl/hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I pipeline types and constants
package rv32i_types;
    typedef enum logic [1:0] {RUN, IWAIT, IWAIT_REDIR} pipe_ctrl_state_t;
    localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and stage load/flush controls of the pipeline sequencer
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             imem_stall;
    logic             dmem_stall;
    logic             clr_cnt;
    logic             pc_load;
    logic             pc_sel_held;
    logic             tgt_latch;
    logic             if_id_load;
    logic             if_id_flush;
    logic             id_ex_load;
    logic             id_ex_flush;
    logic             ex_mem_load;
    logic             mem_wb_load;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_redirect, imem_stall, dmem_stall, clr_cnt,
        input  pc_load, pc_sel_held, tgt_latch, if_id_load, if_id_flush,
               id_ex_load, id_ex_flush, ex_mem_load, mem_wb_load,
               stall_cycles, flush_events
    );
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_redirect, imem_stall, dmem_stall, clr_cnt,
        output pc_load, pc_sel_held, tgt_latch, if_id_load, if_id_flush,
               id_ex_load, id_ex_flush, ex_mem_load, mem_wb_load,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: flags an ID instruction reading the register a load in EX is about to write
module hazard_detect
    import rv32i_types::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    output logic       o_load_use
);
    assign o_load_use = i_ex_mem_read && (i_ex_rd != REG_X0) &&
                        ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with saturating perf counters
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);
    pipe_ctrl_state_t r_state;
    pipe_ctrl_state_t w_next_state;
    logic             w_load_use;
    logic             w_redir_acc;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    hazard_detect u_hazard (
        .i_id_rs1      (bus.id_rs1),
        .i_id_rs2      (bus.id_rs2),
        .i_id_uses_rs1 (bus.id_uses_rs1),
        .i_id_uses_rs2 (bus.id_uses_rs2),
        .i_ex_rd       (bus.ex_rd),
        .i_ex_mem_read (bus.ex_mem_read),
        .o_load_use    (w_load_use)
    );

    // Priority resolution: dmem freeze, then redirect, then load-use, then fetch stall
    always_comb begin
        w_next_state    = r_state;
        w_redir_acc     = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_sel_held = 1'b0;
        bus.tgt_latch   = 1'b0;
        bus.if_id_load  = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_load  = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.ex_mem_load = 1'b0;
        bus.mem_wb_load = 1'b0;
        if (!rst && !bus.dmem_stall) begin
            bus.id_ex_load  = 1'b1;
            bus.ex_mem_load = 1'b1;
            bus.mem_wb_load = 1'b1;
            if (r_state == IWAIT_REDIR) begin
                bus.if_id_load  = 1'b1;
                bus.if_id_flush = 1'b1;
                bus.pc_load     = !bus.imem_stall;
                bus.pc_sel_held = !bus.imem_stall;
                w_next_state    = bus.imem_stall ? IWAIT_REDIR : RUN;
            end else if (bus.ex_redirect) begin
                w_redir_acc     = 1'b1;
                bus.if_id_load  = 1'b1;
                bus.if_id_flush = 1'b1;
                bus.id_ex_flush = 1'b1;
                bus.pc_load     = !bus.imem_stall;
                bus.tgt_latch   = bus.imem_stall;
                w_next_state    = bus.imem_stall ? IWAIT_REDIR : RUN;
            end else begin
                bus.pc_load     = !w_load_use && !bus.imem_stall;
                bus.if_id_load  = !w_load_use;
                bus.if_id_flush = !w_load_use && bus.imem_stall;
                bus.id_ex_flush = w_load_use;
                w_next_state    = bus.imem_stall ? IWAIT : RUN;
            end
        end
    end

    // State register; reset drops any pending redirect
    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_next_state;
    end

    // Saturating counters; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!bus.pc_load && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_redir_acc && (r_flush_events != '1)) r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
endmodule
